// File: rtl/mem_test_engine.sv
// ---------------------------------------------------------------------------
// mem_test_engine
//   Avalon-MM memory traffic generator / checker. One pass over memory is
//   launched by start_i: write-only, read-only or write-then-read. Write data
//   and the expected read data come from the same generator (address-as-data
//   or a 32-bit Galois LFSR). Mismatching read words are counted, and the
//   address of the first one is kept.
//
// Ports
//   clk_i, rst_n_i           clock, async active-low reset
//   start_i                  1-cycle start pulse, accepted only in IDLE
//   mode_i, pattern_i,       pass configuration, latched on accepted start
//   seed_i, base_addr_i,
//   trans_cnt_i, burst_len_i
//   busy_o, done_o           pass in progress / 1-cycle end-of-pass pulse
//   err_cnt_o, err_flag_o,   error status of the last pass
//   err_addr_o
//   mem_*                    Avalon-MM burst master
//
// Handshake: a write beat or a read command is accepted on a rising edge
// where the request (mem_write_o / mem_read_o) is high and
// mem_waitrequest_i is low; until then address, burstcount and write data
// stay constant. Read data is consumed on every edge with
// mem_readdatavalid_i high while a read pass is active; there is no
// back-pressure on returned data.
// ---------------------------------------------------------------------------
module mem_test_engine #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int BURST_W = 11,
  parameter int CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic                  pattern_i,
  input  logic [31:0]           seed_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [CNT_W-1:0]      trans_cnt_i,
  input  logic [BURST_W-1:0]    burst_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           err_cnt_o,
  output logic                  err_flag_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [ADDR_W-1:0]     mem_address_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_W-1:0]     mem_writedata_o,
  output logic [BURST_W-1:0]    mem_burstcount_o,
  output logic [DATA_W/8-1:0]   mem_byteenable_o,
  input  logic                  mem_waitrequest_i,
  input  logic                  mem_readdatavalid_i,
  input  logic [DATA_W-1:0]     mem_readdata_i
);

  localparam int          LANES     = DATA_W / 32;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
  endfunction

  // Lane l of a word: address+l or lfsr^l.
  function automatic logic [DATA_W-1:0] gen_word(input logic [ADDR_W-1:0] addr,
                                                 input logic use_lfsr,
                                                 input logic [31:0] lfsr);
    logic [DATA_W-1:0] w;
    logic [31:0]       a32;
    w   = '0;
    a32 = 32'(addr);
    for (int l = 0; l < LANES; l++) begin
      w[l*32 +: 32] = use_lfsr ? (lfsr ^ 32'(l)) : (a32 + 32'(l));
    end
    return w;
  endfunction

  // FSM and latched configuration
  logic [2:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               pattern_q, pattern_d;
  logic [CNT_W-1:0]   trans_q, trans_d;
  logic [BURST_W-1:0] len_q, len_d;

  // Write side: burst start address, current word address/LFSR, beat/burst
  logic [ADDR_W-1:0]  wr_burst_addr_q, wr_burst_addr_d;
  logic [ADDR_W-1:0]  wr_word_addr_q, wr_word_addr_d;
  logic [31:0]        wr_lfsr_q, wr_lfsr_d;
  logic [BURST_W-1:0] wr_beat_q, wr_beat_d;
  logic [CNT_W-1:0]   wr_burst_q, wr_burst_d;

  // Read command side
  logic [ADDR_W-1:0]  rd_cmd_addr_q, rd_cmd_addr_d;
  logic [CNT_W-1:0]   rd_cmd_cnt_q, rd_cmd_cnt_d;

  // Expected read-data generator, advanced per returned word
  logic [ADDR_W-1:0]  rd_exp_addr_q, rd_exp_addr_d;
  logic [31:0]        rd_lfsr_q, rd_lfsr_d;
  logic [BURST_W-1:0] rd_beat_q, rd_beat_d;
  logic [CNT_W-1:0]   rd_burst_q, rd_burst_d;

  // Error status
  logic [31:0]        err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

  logic               start_ok;
  logic               rd_active;
  logic [BURST_W-1:0] len_m1;
  logic [CNT_W-1:0]   trans_m1;
  logic [ADDR_W-1:0]  len_addr;
  logic [31:0]        seed_eff;
  logic [BURST_W-1:0] len_eff;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  exp_data;

  assign start_ok  = (state_q == S_IDLE) && start_i && (mode_i != 2'b11);
  assign rd_active = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
  assign len_m1    = len_q - BURST_W'(1);
  assign trans_m1  = trans_q - CNT_W'(1);
  assign len_addr  = ADDR_W'(len_q);
  assign seed_eff  = (seed_i == 32'd0) ? 32'd1 : seed_i;
  assign len_eff   = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
  assign wr_data   = gen_word(wr_word_addr_q, pattern_q, wr_lfsr_q);
  assign exp_data  = gen_word(rd_exp_addr_q, pattern_q, rd_lfsr_q);

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    pattern_d       = pattern_q;
    trans_d         = trans_q;
    len_d           = len_q;
    wr_burst_addr_d = wr_burst_addr_q;
    wr_word_addr_d  = wr_word_addr_q;
    wr_lfsr_d       = wr_lfsr_q;
    wr_beat_d       = wr_beat_q;
    wr_burst_d      = wr_burst_q;
    rd_cmd_addr_d   = rd_cmd_addr_q;
    rd_cmd_cnt_d    = rd_cmd_cnt_q;
    rd_exp_addr_d   = rd_exp_addr_q;
    rd_lfsr_d       = rd_lfsr_q;
    rd_beat_d       = rd_beat_q;
    rd_burst_d      = rd_burst_q;
    err_cnt_d       = err_cnt_q;
    err_addr_d      = err_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          mode_d          = mode_i;
          pattern_d       = pattern_i;
          trans_d         = trans_cnt_i;
          len_d           = len_eff;
          // Both generators start from the same seed so reads regenerate writes.
          wr_burst_addr_d = base_addr_i;
          wr_word_addr_d  = base_addr_i;
          wr_lfsr_d       = seed_eff;
          wr_beat_d       = '0;
          wr_burst_d      = '0;
          rd_cmd_addr_d   = base_addr_i;
          rd_cmd_cnt_d    = '0;
          rd_exp_addr_d   = base_addr_i;
          rd_lfsr_d       = seed_eff;
          rd_beat_d       = '0;
          rd_burst_d      = '0;
          err_cnt_d       = '0;
          err_addr_d      = '0;
          if (trans_cnt_i == '0)     state_d = S_DONE;
          else if (mode_i == 2'b01)  state_d = S_RD_REQ;
          else                       state_d = S_WR;
        end
      end
      S_WR: begin
        if (!mem_waitrequest_i) begin
          wr_word_addr_d = wr_word_addr_q + ADDR_W'(1);
          wr_lfsr_d      = lfsr_next(wr_lfsr_q);
          if (wr_beat_q == len_m1) begin
            wr_beat_d       = '0;
            wr_burst_addr_d = wr_burst_addr_q + len_addr;
            wr_burst_d      = wr_burst_q + CNT_W'(1);
            if (wr_burst_q == trans_m1) begin
              state_d = (mode_q == 2'b10) ? S_RD_REQ : S_DONE;
            end
          end else begin
            wr_beat_d = wr_beat_q + BURST_W'(1);
          end
        end
      end
      S_RD_REQ: begin
        if (!mem_waitrequest_i) begin
          rd_cmd_addr_d = rd_cmd_addr_q + len_addr;
          rd_cmd_cnt_d  = rd_cmd_cnt_q + CNT_W'(1);
          if (rd_cmd_cnt_q == trans_m1) state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Returned data is processed independently of command issue, so a word
    // arriving on the same edge as the last command acceptance is not lost.
    if (rd_active && mem_readdatavalid_i) begin
      if (mem_readdata_i != exp_data) begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
        if (err_cnt_q == 32'd0)         err_addr_d = rd_exp_addr_q;
      end
      rd_exp_addr_d = rd_exp_addr_q + ADDR_W'(1);
      rd_lfsr_d     = lfsr_next(rd_lfsr_q);
      if (rd_beat_q == len_m1) begin
        rd_beat_d  = '0;
        rd_burst_d = rd_burst_q + CNT_W'(1);
        if (rd_burst_q == trans_m1) state_d = S_DONE;
      end else begin
        rd_beat_d = rd_beat_q + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= S_IDLE;
      mode_q          <= '0;
      pattern_q       <= 1'b0;
      trans_q         <= '0;
      len_q           <= '0;
      wr_burst_addr_q <= '0;
      wr_word_addr_q  <= '0;
      wr_lfsr_q       <= '0;
      wr_beat_q       <= '0;
      wr_burst_q      <= '0;
      rd_cmd_addr_q   <= '0;
      rd_cmd_cnt_q    <= '0;
      rd_exp_addr_q   <= '0;
      rd_lfsr_q       <= '0;
      rd_beat_q       <= '0;
      rd_burst_q      <= '0;
      err_cnt_q       <= '0;
      err_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      pattern_q       <= pattern_d;
      trans_q         <= trans_d;
      len_q           <= len_d;
      wr_burst_addr_q <= wr_burst_addr_d;
      wr_word_addr_q  <= wr_word_addr_d;
      wr_lfsr_q       <= wr_lfsr_d;
      wr_beat_q       <= wr_beat_d;
      wr_burst_q      <= wr_burst_d;
      rd_cmd_addr_q   <= rd_cmd_addr_d;
      rd_cmd_cnt_q    <= rd_cmd_cnt_d;
      rd_exp_addr_q   <= rd_exp_addr_d;
      rd_lfsr_q       <= rd_lfsr_d;
      rd_beat_q       <= rd_beat_d;
      rd_burst_q      <= rd_burst_d;
      err_cnt_q       <= err_cnt_d;
      err_addr_q      <= err_addr_d;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // forces them to zero immediately.
  assign busy_o           = (state_q == S_WR) || rd_active;
  assign done_o           = (state_q == S_DONE);
  assign mem_write_o      = (state_q == S_WR);
  assign mem_read_o       = (state_q == S_RD_REQ);
  assign mem_address_o    = (state_q == S_WR)     ? wr_burst_addr_q :
                            (state_q == S_RD_REQ) ? rd_cmd_addr_q   : '0;
  assign mem_burstcount_o = ((state_q == S_WR) || (state_q == S_RD_REQ)) ? len_q : '0;
  assign mem_writedata_o  = (state_q == S_WR) ? wr_data : '0;
  assign mem_byteenable_o = '1;
  assign err_cnt_o        = err_cnt_q;
  assign err_flag_o       = (err_cnt_q != 32'd0);
  assign err_addr_o       = err_addr_q;

endmodule

// File: tb/tb_mem_test_engine.sv
// ---------------------------------------------------------------------------
// tb_mem_test_engine
//   Directed bench for mem_test_engine. A behavioural Avalon slave with a
//   word memory answers the DUT; expected write beats, read commands and
//   end-of-pass status are queued when a pass is issued and popped by the
//   monitor as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_mem_test_engine;
  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int BURST_W = 11;
  localparam int CNT_W   = 16;
  localparam int WR_W    = ADDR_W + BURST_W + DATA_W;
  localparam int RC_W    = ADDR_W + BURST_W;
  localparam int DN_W    = 32 + ADDR_W + 1;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                start_i;
  logic [1:0]          mode_i;
  logic                pattern_i;
  logic [31:0]         seed_i;
  logic [ADDR_W-1:0]   base_addr_i;
  logic [CNT_W-1:0]    trans_cnt_i;
  logic [BURST_W-1:0]  burst_len_i;
  logic                busy_o, done_o, err_flag_o;
  logic [31:0]         err_cnt_o;
  logic [ADDR_W-1:0]   err_addr_o;
  logic [ADDR_W-1:0]   mem_address_o;
  logic                mem_read_o, mem_write_o;
  logic [DATA_W-1:0]   mem_writedata_o;
  logic [BURST_W-1:0]  mem_burstcount_o;
  logic [DATA_W/8-1:0] mem_byteenable_o;
  logic                mem_waitrequest_i;
  logic                mem_readdatavalid_i;
  logic [DATA_W-1:0]   mem_readdata_i;

  mem_test_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .start_i            (start_i),
    .mode_i             (mode_i),
    .pattern_i          (pattern_i),
    .seed_i             (seed_i),
    .base_addr_i        (base_addr_i),
    .trans_cnt_i        (trans_cnt_i),
    .burst_len_i        (burst_len_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .err_cnt_o          (err_cnt_o),
    .err_flag_o         (err_flag_o),
    .err_addr_o         (err_addr_o),
    .mem_address_o      (mem_address_o),
    .mem_read_o         (mem_read_o),
    .mem_write_o        (mem_write_o),
    .mem_writedata_o    (mem_writedata_o),
    .mem_burstcount_o   (mem_burstcount_o),
    .mem_byteenable_o   (mem_byteenable_o),
    .mem_waitrequest_i  (mem_waitrequest_i),
    .mem_readdatavalid_i(mem_readdatavalid_i),
    .mem_readdata_i     (mem_readdata_i)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [WR_W-1:0] exp_wr_q[$];
  logic [RC_W-1:0] exp_rd_q[$];
  logic [DN_W-1:0] exp_dn_q[$];

  task automatic check(input string name, input logic [WR_W-1:0] act, input logic [WR_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] y;
    y = {1'b0, x[31:1]};
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [DATA_W-1:0] pat_word(input logic [ADDR_W-1:0] a, input logic p,
                                                 input logic [31:0] l);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W/32; i++)
      w[i*32 +: 32] = p ? (l ^ i) : ({4'b0, a} + i);
    return w;
  endfunction

  // behavioural slave + monitor
  logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];
  bit                corrupt   [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] pend_q[$];
  int                wr_beat  = 0;
  bit                slave_rand = 0;
  int                done_cnt = 0;
  int                wr_seen  = 0;

  always @(negedge clk) begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [WR_W-1:0]   e;
    if (!rst_n) begin
      wr_beat = 0;
      pend_q.delete();
      mem_waitrequest_i   = 1'b0;
      mem_readdatavalid_i = 1'b0;
      mem_readdata_i      = '0;
    end else begin
      if (done_o) begin
        done_cnt++;
        if (exp_dn_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = WR_W'(exp_dn_q.pop_front());
          check("done_status", WR_W'({err_cnt_o, err_addr_o, err_flag_o}), e);
        end
      end
      mem_waitrequest_i = slave_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (pend_q.size() > 0 && (!slave_rand || $urandom_range(0, 3) != 0)) begin
        a = pend_q.pop_front();
        d = mem_model.exists(a) ? mem_model[a] : '0;
        if (corrupt.exists(a)) d[0] = ~d[0];
        mem_readdatavalid_i = 1'b1;
        mem_readdata_i      = d;
      end else begin
        mem_readdatavalid_i = 1'b0;
        mem_readdata_i      = '0;
      end
      if (mem_write_o && !mem_waitrequest_i) begin
        a = mem_address_o + ADDR_W'(wr_beat);
        mem_model[a] = mem_writedata_o;
        wr_seen++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", WR_W'(a), 0);
        else check("wr_beat", {mem_address_o, mem_burstcount_o, mem_writedata_o}, exp_wr_q.pop_front());
        wr_beat++;
        if (wr_beat >= int'(mem_burstcount_o)) wr_beat = 0;
      end
      if (mem_read_o && !mem_waitrequest_i) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", WR_W'(mem_address_o), 0);
        else check("rd_cmd", WR_W'({mem_address_o, mem_burstcount_o}), WR_W'(exp_rd_q.pop_front()));
        for (int k = 0; k < int'(mem_burstcount_o); k++)
          pend_q.push_back(mem_address_o + ADDR_W'(k));
      end
    end
  end

  // driver tasks
  int pass_dn0;

  task automatic issue_pass(input logic [1:0] mode, input logic pat, input logic [31:0] seed,
                            input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] trans,
                            input logic [BURST_W-1:0] len, input logic [31:0] exp_err,
                            input logic [ADDR_W-1:0] exp_eaddr);
    logic [31:0]        s, lf;
    logic [BURST_W-1:0] l;
    logic [ADDR_W-1:0]  ba;
    s = (seed == 0) ? 32'd1 : seed;
    l = (len == 0) ? BURST_W'(1) : len;
    if (mode != 2'b01) begin
      lf = s;
      for (int b = 0; b < int'(trans); b++) begin
        ba = base + ADDR_W'(b * int'(l));
        for (int k = 0; k < int'(l); k++) begin
          exp_wr_q.push_back({ba, l, pat_word(ba + ADDR_W'(k), pat, lf)});
          lf = lfsr_step(lf);
        end
      end
    end
    if (mode != 2'b00)
      for (int b = 0; b < int'(trans); b++)
        exp_rd_q.push_back({base + ADDR_W'(b * int'(l)), l});
    exp_dn_q.push_back({exp_err, exp_eaddr, exp_err != 0});
    pass_dn0 = done_cnt;
    @(negedge clk);
    mode_i = mode; pattern_i = pat; seed_i = seed; base_addr_i = base;
    trans_cnt_i = trans; burst_len_i = len; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    if (trans != 0) check("busy_after_start", WR_W'(busy_o), 1);
    else check("done_after_start", WR_W'({done_o, busy_o}), 2);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && done_cnt == pass_dn0; i++) @(negedge clk);
    if (done_cnt == pass_dn0) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_one_cycle", WR_W'(done_o), 0);
    check("queues_drained", WR_W'(exp_wr_q.size() + exp_rd_q.size() + exp_dn_q.size()), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, WR_W'({busy_o, done_o, mem_write_o, mem_read_o}), 0);
    check({tag, "_bus"}, {mem_address_o, mem_burstcount_o, mem_writedata_o}, 0);
    check({tag, "_be"}, WR_W'(mem_byteenable_o), WR_W'(16'hFFFF));
  endtask

  initial begin
    int w0, d0;
    rst_n = 1'b0; start_i = 1'b0; mode_i = '0; pattern_i = 1'b0; seed_i = '0;
    base_addr_i = '0; trans_cnt_i = '0; burst_len_i = '0;
    mem_waitrequest_i = 1'b0; mem_readdatavalid_i = 1'b0; mem_readdata_i = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_err", WR_W'({err_cnt_o, err_addr_o, err_flag_o}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait write-then-read, address-as-data
    issue_pass(2'b10, 1'b0, 32'd0, 28'h100, 16'd4, 11'd8, 32'd0, 28'h0);
    wait_done();

    // 2: random waitrequest, LFSR seed 0 behaves as seed 1
    slave_rand = 1;
    issue_pass(2'b10, 1'b1, 32'd0, 28'h400, 16'd3, 11'd5, 32'd0, 28'h0);
    wait_done();
    issue_pass(2'b10, 1'b1, 32'd1, 28'h400, 16'd3, 11'd5, 32'd0, 28'h0);
    wait_done();
    slave_rand = 0;

    // 3: two corrupted read words
    corrupt[28'h105] = 1'b1;
    corrupt[28'h10A] = 1'b1;
    issue_pass(2'b10, 1'b0, 32'd0, 28'h100, 16'd2, 11'd8, 32'd2, 28'h105);
    wait_done();
    check("err_flag_after_corrupt", WR_W'({err_flag_o, err_cnt_o, err_addr_o}), WR_W'({1'b1, 32'd2, 28'h105}));
    corrupt.delete();

    // read-only of unwritten memory: every word mismatches
    issue_pass(2'b01, 1'b0, 32'd0, 28'h5000, 16'd1, 11'd4, 32'd4, 28'h5000);
    wait_done();
    // read-only of region written in test 1; errors cleared on start
    issue_pass(2'b01, 1'b0, 32'd0, 28'h100, 16'd4, 11'd8, 32'd0, 28'h0);
    wait_done();

    // 4: address wrap
    issue_pass(2'b10, 1'b0, 32'd0, 28'hFFFFFFC, 16'd1, 11'd8, 32'd0, 28'h0);
    wait_done();

    // burst_len 0 treated as 1, random-ish seed
    issue_pass(2'b10, 1'b1, 32'h1234_5678, 28'h700, 16'd3, 11'd0, 32'd0, 28'h0);
    wait_done();

    // 5: zero transactions
    issue_pass(2'b00, 1'b0, 32'd0, 28'h800, 16'd0, 11'd4, 32'd0, 28'h0);
    wait_done();

    // reserved mode: start ignored
    d0 = done_cnt;
    mode_i = 2'b11; trans_cnt_i = 16'd2; burst_len_i = 11'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("reserved_mode_idle", WR_W'({busy_o, done_cnt != d0}), 0);

    // 6a: start while busy is ignored
    issue_pass(2'b00, 1'b0, 32'd0, 28'h200, 16'd2, 11'd8, 32'd0, 28'h0);
    mode_i = 2'b01; base_addr_i = 28'h900; trans_cnt_i = 16'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();

    // 6b: reset in the middle of a write pass
    issue_pass(2'b00, 1'b1, 32'd5, 28'h300, 16'd4, 11'd8, 32'd0, 28'h0);
    w0 = wr_seen;
    for (int i = 0; i < 200 && wr_seen < w0 + 5; i++) @(negedge clk);
    check("midwr_progress", WR_W'(wr_seen >= w0 + 5), 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    exp_wr_q.delete(); exp_rd_q.delete(); exp_dn_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", WR_W'(done_cnt), WR_W'(d0));
    check_idle_outputs("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
